// File: rtl/tmux_demux.sv
// Reassembles IN1/IN2 beats from a time-multiplexed bus into pairs and queues them in a small FIFO.
// Latency: an IN2 beat accepted at edge N makes its pair visible on out_* right after edge N (empty FIFO).
// Backpressure: in_ready is registered !full, so it has no combinational path from out_ready; IN1 is refused too when full.
//
// Ports:
//   clk, resetl           clock, asynchronous active-low reset
//   in_data/in_sel/in_valid/in_ready   multiplexed beat input (sel 0 = IN1, 1 = IN2)
//   out_in1/out_in2/out_valid/out_ready  reassembled pair output, driven from FIFO head storage
//   seq_err               one-cycle registered pulse per out-of-order beat
// Optional: define TMUX_DEMUX_ERRCNT_EN to add err_clr (input) and err_count (8-bit saturating error count).

module tmux_demux #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         resetl,
    input  logic [W-1:0] in_data,
    input  logic         in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_in1,
    output logic [W-1:0] out_in2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         seq_err
`ifdef TMUX_DEMUX_ERRCNT_EN
    ,
    input  logic         err_clr,
    output logic [7:0]   err_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        S_WAIT1 = 1'b0,
        S_WAIT2 = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_half;
    logic [W-1:0]   r_mem1 [DEPTH];
    logic [W-1:0]   r_mem2 [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic [AW:0]    w_count_nxt;
    logic           r_in_ready;
    logic           r_seq_err;

    logic           w_accept;
    logic           w_pop;
    logic           w_push;
    logic           w_cap;
    logic           w_err;

    assign w_accept  = in_valid & r_in_ready;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;
    assign out_in1   = r_mem1[r_rptr];
    assign out_in2   = r_mem2[r_rptr];
    assign in_ready  = r_in_ready;
    assign seq_err   = r_seq_err;

    // Assembler: only accepted beats move it. A repeated IN1 replaces the
    // stored half (newest IN1 wins); an orphan IN2 is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_cap       = 1'b0;
        w_err       = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_WAIT1: begin
                    if (!in_sel) begin
                        w_cap       = 1'b1;
                        w_state_nxt = S_WAIT2;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_WAIT2: begin
                    if (in_sel) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_WAIT1;
                    end else begin
                        w_cap = 1'b1;
                        w_err = 1'b1;
                    end
                end
                default: w_state_nxt = S_WAIT1;
            endcase
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_state    <= S_WAIT1;
            r_half     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_seq_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem1[i] <= '0;
                r_mem2[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_seq_err  <= w_err;
            r_count    <= w_count_nxt;
            // Ready for the next cycle follows the post-update occupancy.
            r_in_ready <= (w_count_nxt != CNT_FULL);
            if (w_cap) begin
                r_half <= in_data;
            end
            if (w_push) begin
                r_mem1[r_wptr] <= r_half;
                r_mem2[r_wptr] <= in_data;
                r_wptr         <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

`ifdef TMUX_DEMUX_ERRCNT_EN
    logic [7:0] r_err_count;
    assign err_count = r_err_count;

    // Counted on the same edge that raises seq_err; clear wins over increment.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_err_count <= 8'd0;
        end else if (err_clr) begin
            r_err_count <= 8'd0;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tmux_demux.sv
module tb_tmux_demux;

    localparam int W     = 8;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         resetl = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_in1;
    logic [W-1:0] out_in2;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         seq_err;
`ifdef TMUX_DEMUX_ERRCNT_EN
    logic         err_clr = 1'b0;
    logic [7:0]   err_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    tmux_demux #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetl    (resetl),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_in1   (out_in1),
        .out_in2   (out_in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .seq_err   (seq_err)
`ifdef TMUX_DEMUX_ERRCNT_EN
        ,
        .err_clr   (err_clr),
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of completed pairs plus an optional pending IN1 half.
    logic [2*W-1:0] m_q[$];
    bit             m_have  = 1'b0;
    logic [W-1:0]   m_half  = '0;
    bit             m_err   = 1'b0;
    bit             m_ready = 1'b0;
    int             m_cnt   = 0;

    always @(posedge clk or negedge resetl) begin
        bit acc;
        bit pop;
        if (!resetl) begin
            m_q.delete();
            m_have  = 1'b0;
            m_err   = 1'b0;
            m_ready = 1'b0;
            m_cnt   = 0;
        end else begin
            acc   = in_valid && m_ready;
            pop   = (m_q.size() != 0) && out_ready;
            m_err = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                if (!in_sel) begin
                    if (m_have) m_err = 1'b1;
                    m_have = 1'b1;
                    m_half = in_data;
                end else if (m_have) begin
                    m_q.push_back({m_half, in_data});
                    m_have = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
`ifdef TMUX_DEMUX_ERRCNT_EN
            if (err_clr) m_cnt = 0;
            else if (m_err && m_cnt < 255) m_cnt++;
`endif
            m_ready = (m_q.size() < DEPTH);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", out_valid, (m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("out_in1", out_in1, m_q[0][2*W-1:W]);
            chk("out_in2", out_in2, m_q[0][W-1:0]);
        end
        chk("in_ready", in_ready, m_ready);
        chk("seq_err", seq_err, m_err);
`ifdef TMUX_DEMUX_ERRCNT_EN
        chk("err_count", err_count, m_cnt);
`endif
    end

    // Present one beat and hold it until the DUT takes it; returns 2 time units after the accepting edge.
    task automatic send(input logic s, input logic [W-1:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            done = in_ready;
            @(posedge clk);
            #2;
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 resetl = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_in1", out_in1, 0);
        chk("rst_out_in2", out_in2, 0);
        chk("rst_seq_err", seq_err, 0);
        repeat (2) step();
        resetl = 1'b1;
        #1;
        chk("ready_before_edge", in_ready, 0);
        step();
        chk("ready_after_edge", in_ready, 1);

        // Basic pair, one-cycle latency, then popped.
        out_ready = 1'b1;
        send(1'b0, 8'h12);
        send(1'b1, 8'h34);
        chk("t1_valid", out_valid, 1);
        chk("t1_in1", out_in1, 8'h12);
        chk("t1_in2", out_in2, 8'h34);
        step();
        chk("t1_valid_gone", out_valid, 0);

        // Backpressure with a full FIFO; C1 must wait.
        out_ready = 1'b0;
        send(1'b0, 8'hA1);
        send(1'b1, 8'hA2);
        send(1'b0, 8'hB1);
        send(1'b1, 8'hB2);
        chk("t2_full_ready", in_ready, 0);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'hC1;
        repeat (3) step();
        chk("t2_hold_ready", in_ready, 0);
        chk("t2_hold_in1", out_in1, 8'hA1);
        chk("t2_hold_in2", out_in2, 8'hA2);
        out_ready = 1'b1;
        send(1'b0, 8'hC1);
        send(1'b1, 8'hC2);
        repeat (4) step();

        // Orphan IN2 then a good pair.
        send(1'b1, 8'h55);
        chk("t3_orphan_err", seq_err, 1);
        chk("t3_no_push", out_valid, 0);
        send(1'b0, 8'h01);
        chk("t3_err_gone", seq_err, 0);
        send(1'b1, 8'h02);
        chk("t3_in1", out_in1, 8'h01);
        chk("t3_in2", out_in2, 8'h02);
        step();

        // Repeated IN1: the newer half wins.
        send(1'b0, 8'hAA);
        send(1'b0, 8'hBB);
        chk("t4_rep_err", seq_err, 1);
        send(1'b1, 8'hCC);
        chk("t4_in1", out_in1, 8'hBB);
        chk("t4_in2", out_in2, 8'hCC);
        step();

        // Steady stream, pointers wrap many times.
        for (int p = 0; p < 32; p++) begin
            send(1'b0, 8'($urandom));
            send(1'b1, 8'($urandom));
        end
        repeat (3) step();

        // Random traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = ($urandom_range(0, 9) < 5);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        // Reset mid-pair with one pair queued.
        out_ready = 1'b0;
        send(1'b0, 8'h11);
        send(1'b1, 8'h22);
        send(1'b0, 8'h77);
        #1 resetl = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_ready", in_ready, 0);
        chk("t6_async_in1", out_in1, 0);
        repeat (2) step();
        resetl = 1'b1;
        step();
        out_ready = 1'b1;
        send(1'b1, 8'h99);
        chk("t6_half_dropped", seq_err, 1);
        chk("t6_empty", out_valid, 0);
        send(1'b0, 8'h03);
        send(1'b1, 8'h04);
        chk("t6_in1", out_in1, 8'h03);
        chk("t6_in2", out_in2, 8'h04);
        step();

`ifdef TMUX_DEMUX_ERRCNT_EN
        for (int k = 0; k < 300; k++) send(1'b1, 8'($urandom));
        step();
        chk("t7_saturate", err_count, 255);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t7_clear", err_count, 0);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
